// File: rtl/instr_fetch_requester.sv
// rtl/instr_fetch_requester.sv - Instruction fetch initiator: sequential req/gnt/rvalid fetches into an in-order buffer
module instr_fetch_requester #(
    parameter logic [31:0] BOOT_ADDR       = 32'h0000_0080,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          FIFO_DEPTH      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_rdata_o,
    output logic [31:0] out_addr_o,
    output logic        out_err_o,
    output logic        busy_o
);
    localparam int          PW      = $clog2(FIFO_DEPTH);
    localparam logic [3:0]  MAX_OUT = 4'(MAX_OUTSTANDING);
    localparam logic [4:0]  DEPTH   = 5'(FIFO_DEPTH);
    localparam logic [31:0] BOOT    = {BOOT_ADDR[31:2], 2'b00};

    typedef enum logic {IDLE, REQ} state_t;
    state_t state_q, state_n;

    logic [31:0] addr_q, addr_n;
    logic [31:0] fetch_q, fetch_n;
    logic [3:0]  outst_q, outst_n;
    logic [3:0]  disc_q, disc_n;
    logic [3:0]  cnt_q, cnt_n;
    logic        stale_q, stale_n;

    logic [31:0] aq_mem [4];
    logic [1:0]  aq_wr_q, aq_rd_q;

    logic [31:0]           fd_mem [FIFO_DEPTH];
    logic [31:0]           fa_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fe_mem;
    logic [PW-1:0]         wr_q, rd_q;

    logic gnt_acc, rv_acc, push, pop, issue;

    assign instr_req_o  = (state_q == REQ);
    assign instr_addr_o = addr_q;
    assign gnt_acc      = instr_req_o && instr_gnt_i;
    assign rv_acc       = instr_rvalid_i && (outst_q != 4'd0);
    assign push         = rv_acc && (disc_q == 4'd0) && !branch_i;
    assign pop          = out_valid_o && out_ready_i && !branch_i;

    assign out_valid_o = (cnt_q != 4'd0);
    assign out_rdata_o = fd_mem[rd_q];
    assign out_addr_o  = fa_mem[rd_q];
    assign out_err_o   = fe_mem[rd_q];
    assign busy_o      = instr_req_o || (outst_q != 4'd0);

    always_comb begin
        state_n = state_q;
        addr_n  = addr_q;
        fetch_n = fetch_q;
        stale_n = stale_q;
        outst_n = outst_q + {3'b000, gnt_acc} - {3'b000, rv_acc};
        cnt_n   = cnt_q + {3'b000, push} - {3'b000, pop};
        disc_n  = disc_q + {3'b000, gnt_acc && stale_q}
                         - {3'b000, rv_acc && (disc_q != 4'd0)};
        if (branch_i) begin
            // Everything in flight after this edge belongs to the old stream.
            cnt_n   = 4'd0;
            disc_n  = outst_n;
            stale_n = instr_req_o && !instr_gnt_i;
            fetch_n = {branch_addr_i[31:2], 2'b00};
        end else if (gnt_acc) begin
            stale_n = 1'b0;
            if (!stale_q) begin
                fetch_n = fetch_q + 32'd4;
            end
        end
        // Credits are judged on post-edge counts so every response has a slot.
        issue = fetch_en_i && (outst_n < MAX_OUT)
                && (({1'b0, outst_n} + {1'b0, cnt_n}) < DEPTH)
                && (disc_n == 4'd0) && !stale_n;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_n = REQ;
                    addr_n  = fetch_n;
                end
            end
            REQ: begin
                if (gnt_acc) begin
                    if (issue) begin
                        addr_n = fetch_n;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            fetch_q <= BOOT;
            outst_q <= '0;
            disc_q  <= '0;
            cnt_q   <= '0;
            stale_q <= 1'b0;
            aq_wr_q <= '0;
            aq_rd_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            fe_mem  <= '0;
            for (int i = 0; i < 4; i++) begin
                aq_mem[i] <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fd_mem[i] <= '0;
                fa_mem[i] <= '0;
            end
        end else begin
            state_q <= state_n;
            addr_q  <= addr_n;
            fetch_q <= fetch_n;
            outst_q <= outst_n;
            disc_q  <= disc_n;
            cnt_q   <= cnt_n;
            stale_q <= stale_n;
            if (gnt_acc) begin
                aq_mem[aq_wr_q] <= addr_q;
                aq_wr_q         <= aq_wr_q + 2'd1;
            end
            if (rv_acc) begin
                aq_rd_q <= aq_rd_q + 2'd1;
            end
            if (push) begin
                fd_mem[wr_q] <= instr_rdata_i;
                fa_mem[wr_q] <= aq_mem[aq_rd_q];
                fe_mem[wr_q] <= instr_err_i;
                wr_q         <= wr_q + PW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + PW'(1);
            end
            if (branch_i) begin
                wr_q <= '0;
                rd_q <= '0;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_requester.sv
// tb/tb_instr_fetch_requester.sv - Bench for instr_fetch_requester with memory responder and queue model
module tb_instr_fetch_requester;
    localparam logic [31:0] BOOT  = 32'h0000_0080;
    localparam int          MAXO  = 2;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_rdata;
    logic [31:0] out_addr;
    logic        out_err;
    logic        busy;

    always #5 clk = ~clk;

    instr_fetch_requester #(
        .BOOT_ADDR(BOOT), .MAX_OUTSTANDING(MAXO), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .fetch_en_i(fetch_en), .branch_i(branch),
        .branch_addr_i(branch_addr), .instr_req_o(req), .instr_addr_o(addr),
        .instr_gnt_i(gnt), .instr_rvalid_i(rvalid), .instr_rdata_i(rdata),
        .instr_err_i(err), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_rdata_o(out_rdata), .out_addr_o(out_addr), .out_err_o(out_err),
        .busy_o(busy)
    );

    typedef struct packed { logic drop; logic [31:0] addr; } inf_t;
    typedef struct packed { logic [31:0] addr; logic err; } ent_t;
    typedef struct packed { logic [31:0] addr; logic [31:0] rdy; } rsp_t;

    inf_t        inflight[$];
    ent_t        exp_out[$];
    rsp_t        rsp_q[$];
    logic [31:0] gnt_log[$];
    int          gnt_cyc[$];
    ent_t        dlv_log[$];
    int          dlv_cyc[$];

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          gnt_delay = 0;
    int          rsp_lat = 1;
    int          wait_cnt = 0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    logic [31:0] exp_fetch = BOOT;
    logic [31:0] stale_addr = '0;
    bit          stale_pend = 1'b0;
    logic        prev_req = 1'b0;
    logic        prev_gnt = 1'b0;
    logic [31:0] prev_addr = '0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic logic [31:0] gl(input int i);
        if (i < gnt_log.size()) return gnt_log[i];
        return 32'hDEAD_BEEF;
    endfunction
    function automatic int gc(input int i);
        if (i < gnt_cyc.size()) return gnt_cyc[i];
        return -1000;
    endfunction
    function automatic ent_t dl(input int i);
        if (i < dlv_log.size()) return dlv_log[i];
        return {32'hDEAD_BEEF, 1'b1};
    endfunction
    function automatic int dc(input int i);
        if (i < dlv_cyc.size()) return dlv_cyc[i];
        return -1000;
    endfunction

    // Memory responder: grants after gnt_delay waiting cycles, answers in order rsp_lat cycles after grant.
    initial begin
        rsp_t r;
        gnt = 1'b0; rvalid = 1'b0; rdata = '0; err = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (req) begin
                gnt = (wait_cnt >= gnt_delay);
                wait_cnt = gnt ? 0 : wait_cnt + 1;
            end else begin
                gnt = 1'b0;
                wait_cnt = 0;
            end
            if (rsp_q.size() != 0 && rsp_q[0].rdy <= 32'(cyc)) begin
                r = rsp_q.pop_front();
                rvalid = 1'b1;
                rdata = mem_data(r.addr);
                err = (r.addr == err_addr);
            end else begin
                rvalid = 1'b0;
                rdata = '0;
                err = 1'b0;
            end
        end
    end

    // Reference model: expected stream = in-order responses of non-stale grants, flushed on branch.
    always @(negedge clk) begin
        logic [31:0] ea;
        logic        d;
        inf_t        f;
        if (rst) begin
            inflight.delete();
            exp_out.delete();
            exp_fetch = BOOT;
            stale_pend = 1'b0;
            prev_req = 1'b0;
            prev_gnt = 1'b0;
        end else begin
            chk(out_valid == (exp_out.size() != 0), "out_valid", out_valid, exp_out.size() != 0);
            if (out_valid && exp_out.size() != 0) begin
                chk(out_addr == exp_out[0].addr, "out_addr", out_addr, exp_out[0].addr);
                chk(out_rdata == mem_data(exp_out[0].addr), "out_rdata", out_rdata, mem_data(exp_out[0].addr));
                chk(out_err == exp_out[0].err, "out_err", out_err, exp_out[0].err);
            end
            chk(busy == (req || inflight.size() != 0), "busy", busy, req || inflight.size() != 0);
            if (prev_req && !prev_gnt)
                chk(req && addr == prev_addr, "req_hold", addr, prev_addr);
            chk(inflight.size() <= MAXO && inflight.size() + exp_out.size() <= DEPTH,
                "credit", inflight.size() + exp_out.size(), DEPTH);

            if (out_valid && out_ready && !branch) begin
                dlv_log.push_back({out_addr, out_err});
                dlv_cyc.push_back(cyc);
                if (exp_out.size() != 0) void'(exp_out.pop_front());
            end
            if (rvalid && inflight.size() != 0) begin
                f = inflight.pop_front();
                if (!f.drop) exp_out.push_back({f.addr, err});
            end
            if (req && gnt) begin
                if (stale_pend) begin
                    ea = stale_addr; d = 1'b1; stale_pend = 1'b0;
                end else begin
                    ea = exp_fetch; d = 1'b0; exp_fetch = exp_fetch + 32'd4;
                end
                chk(addr == ea, "gnt_addr", addr, ea);
                inflight.push_back({d, ea});
                gnt_log.push_back(addr);
                gnt_cyc.push_back(cyc);
                rsp_q.push_back({addr, 32'(cyc + rsp_lat)});
            end
            if (branch) begin
                foreach (inflight[i]) inflight[i].drop = 1'b1;
                exp_out.delete();
                if (req && !gnt && !stale_pend) begin
                    stale_pend = 1'b1;
                    stale_addr = exp_fetch;
                end
                exp_fetch = {branch_addr[31:2], 2'b00};
            end
            prev_req = req;
            prev_gnt = gnt;
            prev_addr = addr;
        end
    end

    task automatic chk_reset_outs();
        chk(req == 1'b0, "rst_req", req, 0);
        chk(addr == 32'd0, "rst_addr", addr, 0);
        chk(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
        chk(out_rdata == 32'd0, "rst_out_rdata", out_rdata, 0);
        chk(out_addr == 32'd0, "rst_out_addr", out_addr, 0);
        chk(out_err == 1'b0, "rst_out_err", out_err, 0);
        chk(busy == 1'b0, "rst_busy", busy, 0);
    endtask

    task automatic clear_logs();
        gnt_log.delete(); gnt_cyc.delete(); dlv_log.delete(); dlv_cyc.delete();
    endtask

    task automatic do_reset(input bit flush);
        @(posedge clk); #1;
        rst = 1'b1; fetch_en = 1'b0; branch = 1'b0;
        if (flush) rsp_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk_reset_outs();
        @(posedge clk); #1;
        rst = 1'b0;
        wait_cnt = 0;
        clear_logs();
    endtask

    task automatic wait_model(input int n_inf, input int n_out, input string nm);
        bit hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(negedge clk); #1;
            hit = (inflight.size() == n_inf) && (exp_out.size() >= n_out);
        end
        chk(hit, nm, inflight.size(), n_inf);
    endtask

    initial begin
        int nb, nd;
        bit hit;
        // Zero-wait memory: one fetch and one delivered word per cycle.
        do_reset(1'b1);
        fetch_en = 1'b1;
        repeat (20) @(posedge clk);
        #1 fetch_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk(gl(i) == BOOT + 32'(4 * i), "zw_gnt_addr", gl(i), BOOT + 32'(4 * i));
            chk(gc(i) - gc(0) == i, "zw_gnt_cycle", gc(i) - gc(0), i);
            chk(dl(i).addr == BOOT + 32'(4 * i), "zw_dlv_addr", dl(i).addr, BOOT + 32'(4 * i));
            chk(dc(i) - dc(0) == i, "zw_dlv_cycle", dc(i) - dc(0), i);
        end

        // Grant delayed three cycles: request holds, one push per grant.
        do_reset(1'b1);
        gnt_delay = 3;
        fetch_en = 1'b1;
        repeat (20) @(posedge clk);
        #1 fetch_en = 1'b0;
        repeat (12) @(posedge clk);
        chk(gl(0) == 32'h80, "dly_gnt0", gl(0), 32'h80);
        chk(gl(1) == 32'h84, "dly_gnt1", gl(1), 32'h84);
        chk(gc(1) - gc(0) == 4, "dly_gnt_spacing", gc(1) - gc(0), 4);
        chk(dlv_log.size() == gnt_log.size(), "dly_push_per_gnt", dlv_log.size(), gnt_log.size());
        gnt_delay = 0;

        // Consumer stalled: credits stop issue after four grants, resume at 0x90.
        do_reset(1'b1);
        out_ready = 1'b0;
        fetch_en = 1'b1;
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk(gnt_log.size() == 4, "bp_grants", gnt_log.size(), 4);
        chk(req == 1'b0, "bp_req_low", req, 0);
        chk(out_valid == 1'b1, "bp_out_valid", out_valid, 1);
        @(posedge clk); #1 out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 fetch_en = 1'b0;
        chk(gl(4) == 32'h90, "bp_resume_addr", gl(4), 32'h90);
        chk(dl(0).addr == 32'h80, "bp_first_dlv", dl(0).addr, 32'h80);
        repeat (8) @(posedge clk);

        // Branch with two outstanding and a part-filled buffer.
        do_reset(1'b1);
        rsp_lat = 3;
        out_ready = 1'b0;
        fetch_en = 1'b1;
        wait_model(2, 2, "br_setup");
        @(posedge clk); #1;
        branch = 1'b1; branch_addr = 32'h0000_1002; out_ready = 1'b1;
        nb = gnt_log.size(); nd = dlv_log.size();
        @(posedge clk); #1 branch = 1'b0;
        @(negedge clk);
        chk(out_valid == 1'b0, "br_flush", out_valid, 0);
        repeat (20) @(posedge clk);
        #1 fetch_en = 1'b0;
        repeat (10) @(posedge clk);
        chk(gl(nb) == 32'h1000, "br_next_req", gl(nb), 32'h1000);
        chk(dl(nd).addr == 32'h1000, "br_first_dlv", dl(nd).addr, 32'h1000);
        chk(nd == 0, "br_none_before", nd, 0);

        // Bus error on 0x84 marks only that entry.
        do_reset(1'b1);
        rsp_lat = 1;
        err_addr = 32'h84;
        fetch_en = 1'b1;
        repeat (12) @(posedge clk);
        #1 fetch_en = 1'b0;
        chk(dl(0).err == 1'b0, "err_e0", dl(0).err, 0);
        chk(dl(1).addr == 32'h84 && dl(1).err == 1'b1, "err_e1", {dl(1).addr[30:0], dl(1).err}, {31'h84, 1'b1});
        chk(dl(2).addr == 32'h88 && dl(2).err == 1'b0, "err_e2", {dl(2).addr[30:0], dl(2).err}, {31'h88, 1'b0});
        err_addr = 32'hFFFF_FFFF;
        repeat (4) @(posedge clk);

        // Reset mid-transaction; late responses must be ignored.
        do_reset(1'b1);
        rsp_lat = 3;
        fetch_en = 1'b1;
        wait_model(2, 0, "rst_setup");
        do_reset(1'b0);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(posedge clk); #2;
            hit = (rsp_q.size() == 0);
        end
        chk(hit, "rst_drain", rsp_q.size(), 0);
        repeat (2) @(posedge clk);
        chk(dlv_log.size() == 0, "rst_stale_ignored", dlv_log.size(), 0);
        #1 fetch_en = 1'b1;
        repeat (8) @(posedge clk);
        #1 fetch_en = 1'b0;
        chk(gl(0) == BOOT, "rst_boot_req", gl(0), BOOT);
        repeat (8) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_chk);
        $fatal(1);
    end
endmodule

// File: doc/instr_fetch_requester.md
Name: instr_fetch_requester

Overview:
- Initiator (core) side of the instruction memory req/gnt/rvalid protocol; the counterpart of the memory responder that the testbench driver models.
- Issues word-aligned sequential fetches, tracks outstanding requests and buffers returned words in a small in-order FIFO toward the decode stage.
- Handles redirects (branches) by flushing the FIFO and discarding stale in-flight responses.

Parameters:
- BOOT_ADDR, 32'h0000_0080, first fetch address after reset (bits [1:0] forced to 0).
- MAX_OUTSTANDING, 2, maximum granted-but-not-responded requests (1..4).
- FIFO_DEPTH, 4, instruction buffer entries (power of 2, 2..8, >= MAX_OUTSTANDING).

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- fetch_en_i  input  1  permits issuing new requests
- branch_i  input  1  one-cycle redirect pulse
- branch_addr_i  input  32  redirect target (bits [1:0] ignored)
- instr_req_o  output  1  request valid
- instr_addr_o  output  32  request word address
- instr_gnt_i  input  1  request accepted
- instr_rvalid_i  input  1  response valid (in order)
- instr_rdata_i  input  32  response data
- instr_err_i  input  1  response bus error, qualified by rvalid
- out_valid_o  output  1  buffered instruction available
- out_ready_i  input  1  consumer accepts head entry
- out_rdata_o  output  32  head instruction word
- out_addr_o  output  32  address of head word
- out_err_o  output  1  head entry carried a bus error
- busy_o  output  1  any outstanding request or pending req

Behaviour:
- Reset: instr_req_o=0, instr_addr_o=0, out_valid_o=0, out_rdata_o=0, out_addr_o=0, out_err_o=0, busy_o=0. FIFO empty, outstanding=0, discard=0, next fetch address=BOOT_ADDR. Reset mid-transaction abandons everything; responses arriving after reset deasserts are ignored while outstanding=0.
- Issue condition: fetch_en_i && outstanding<MAX_OUTSTANDING && (outstanding+fifo_count)<FIFO_DEPTH && discard==0. This credit rule guarantees FIFO space for every response.
- instr_req_o and instr_addr_o are registered. Once req=1, req and addr hold stable until the cycle instr_gnt_i=1. Holding applies even if fetch_en_i drops or a branch arrives; no retraction.
- On the gnt cycle: outstanding++, address FIFO records addr, fetch address += 4 (wraps 32'hFFFF_FFFC -> 0). req may stay high next cycle (back-to-back) if the issue condition still holds.
- On rvalid: outstanding--.
  - If discard>0: discard--, data dropped.
  - Else push {rdata, addr, err} into FIFO.
  - rvalid with outstanding==0 is ignored.
  - gnt and rvalid in the same cycle (different requests) both take effect.
- Latency: rvalid at cycle N -> out_valid_o=1 at N+1 when the FIFO was empty (registered output, no fall-through).
- Output: head popped when out_valid_o && out_ready_i. Push and pop in the same cycle keep count unchanged. Bus errors do not stop fetching.
- Branch (branch_i=1 at cycle N):
  - FIFO flushed; out_valid_o=0 at N+1, overriding any same-cycle pop.
  - discard = outstanding + (gnt at N ? 1 : 0) - (rvalid at N ? 1 : 0). A pending un-granted request also increments discard when it is later granted.
  - Fetch address = branch_addr_i & ~3.
  - New requests resume only once discard==0 and no stale req is pending.
  - A second branch before recovery simply overwrites the target.
- State machine:
  - IDLE (req=0) -> REQ when the issue condition holds.
  - REQ -> REQ on gnt with the condition still true; REQ -> IDLE on gnt with the condition false; REQ -> REQ without gnt.
  - In REQ a branch marks the pending request stale. The stale request is granted, and the new target issues only after drain.
- busy_o = instr_req_o || outstanding!=0.

Test Plan:
- Zero-wait memory (gnt same cycle as req, rvalid next cycle), fetch_en=1, out_ready=1 -> addresses 0x80,0x84,0x88,... on consecutive cycles; out_addr_o follows the same sequence, one word per cycle.
- gnt delayed 3 cycles -> req/addr (0x80) stable for all 4 cycles; only one push per gnt.
- out_ready=0, FIFO_DEPTH=4, MAX_OUTSTANDING=2 -> exactly 4 grants, then req stays 0; out_ready=1 -> fetching resumes at 0x90.
- Branch to 0x1002 with 2 outstanding -> both responses dropped, out_valid=0; next req addr=0x1000; first delivered out_addr_o=0x1000.
- rvalid with err=1 for 0x84 -> entry out_err_o=1, out_addr_o=0x84; next entry 0x88 has err=0.
- rst asserted with 2 outstanding, released -> all outputs at reset values; stale rvalids ignored; first req at BOOT_ADDR.
